// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and types
package uart_pkg;
  localparam int UART_DATA_BITS        = 8;
  localparam int UART_TX_FIFO_DEPTH    = 8;
  localparam int UART_DEFAULT_BAUD_DIV = 434;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  typedef logic [7:0] uart_byte_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with occupancy count, shared by TX and RX
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - buffered UART transmitter producing 8N1 / 8E1 / 8O1 frames
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH,
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  uart_byte_t                  wr_data,
  input  logic                        wr_en,
  input  logic [BAUD_DIV_W-1:0]       baud_div,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        clr_overflow,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx_done,
  output logic                        tx
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [BAUD_DIV_W-1:0] ONE = BAUD_DIV_W'(1);

  uart_tx_state_t        state_q;
  logic [BAUD_DIV_W-1:0] cnt_q, bit_len_q, baud_eff;
  logic [IDX_W-1:0]      bit_idx_q;
  uart_byte_t            shift_q, fifo_rd_data;
  logic                  parity_q, par_en_q, tx_q, tx_done_q, overflow_q;
  logic                  pop, bit_end, near_end, last_data;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_en),
    .push_data_i(wr_data),
    .pop_i      (pop),
    .pop_data_o (fifo_rd_data),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  assign baud_eff  = (baud_div == '0) ? ONE : baud_div;
  assign bit_end   = (cnt_q == bit_len_q - ONE);
  assign near_end  = (cnt_q + ONE == bit_len_q - ONE);
  assign last_data = (bit_idx_q == IDX_W'(DATA_BITS - 1));
  // Popping at the end of STOP chains frames with no idle cycle in between.
  assign pop       = !empty && ((state_q == IDLE) || (state_q == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_len_q <= ONE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (pop) begin
        state_q   <= START;
        cnt_q     <= '0;
        bit_len_q <= baud_eff;
        par_en_q  <= parity_en;
        shift_q   <= fifo_rd_data;
        parity_q  <= (^fifo_rd_data) ^ parity_odd;
        tx_q      <= 1'b0;
      end else if (state_q != IDLE) begin
        if (!bit_end) begin
          cnt_q     <= cnt_q + ONE;
          tx_done_q <= (state_q == STOP) && near_end;
        end else begin
          cnt_q <= '0;
          case (state_q)
            START: begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              tx_q      <= shift_q[0];
            end
            DATA: begin
              if (!last_data) begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
                shift_q   <= shift_q >> 1;
                tx_q      <= shift_q[1];
              end else if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q   <= STOP;
                tx_q      <= 1'b1;
                tx_done_q <= (bit_len_q == ONE);
              end
            end
            PARITY: begin
              state_q   <= STOP;
              tx_q      <= 1'b1;
              tx_done_q <= (bit_len_q == ONE);
            end
            default: begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else if (wr_en && full && !pop) overflow_q <= 1'b1;
    else if (clr_overflow) overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign tx_done  = tx_done_q;
  assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine
module tb_uart_tx_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_en = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0, parity_odd = 1'b0, clr_overflow = 1'b0;
  logic        full, empty, overflow, busy, tx_done, tx;
  logic [3:0]  level;

  uart_tx_engine #(.FIFO_DEPTH(8), .DATA_BITS(8), .BAUD_DIV_W(16)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .clr_overflow(clr_overflow),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .busy(busy), .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         bl;
    int         pen;
    logic       pbit;
  } frame_t;

  frame_t exp_q[$];
  logic   samp[$];
  int     done_cyc[$];
  int     checks = 0, errors = 0;
  int     cyc = 0, done_cnt = 0, lvl_max = 0;
  frame_t cur;
  int     bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input frame_t f, input int j);
    int slot = j / f.bl;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return f.data[slot-1];
    if (slot == 9 && f.pen != 0) return f.pbit;
    return 1'b1;
  endfunction

  // Monitor: collects the line while busy and scores each frame on its tx_done.
  always @(negedge clk) begin
    if (rst) samp.delete();
    else begin
      if (busy) samp.push_back(tx);
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (tx_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          cur = exp_q.pop_front();
          check("frame_len", samp.size(), (10 + cur.pen) * cur.bl);
          bad = 0;
          foreach (samp[j]) if (samp[j] !== exp_bit(cur, j)) bad++;
          check("frame_bits", bad, 0);
        end
        samp.delete();
      end
    end
  end

  task automatic write(input logic [7:0] d, input int bl, input int pen, input logic pbit, input bit expect_tx);
    wr_data = d;
    wr_en   = 1'b1;
    if (expect_tx) exp_q.push_back('{data: d, bl: bl, pen: pen, pbit: pbit});
    @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((busy || !empty || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= max_cyc), 0);
  endtask

  initial begin
    int w, d0, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // 8N1, 4 cycles per bit
    baud_div = 16'd4; parity_en = 1'b0;
    w = cyc;
    write(8'hA5, 4, 0, 1'b0, 1'b1);
    wr_en = 1'b0;
    check("tx_high_after_write", tx, 1);
    check("busy_after_write", busy, 0);
    @(negedge clk);
    check("tx_start_low", tx, 0);
    check("busy_in_frame", busy, 1);
    drain(200);
    check("a5_done_cycle", done_cyc[done_cyc.size()-1], w + 41);
    check("busy_dropped", busy, 0);

    // even then odd parity; parity_en change mid-frame must be ignored
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0;
    write(8'h07, 2, 1, 1'b1, 1'b1);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    parity_en = 1'b0; baud_div = 16'd9;
    drain(200);
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b1;
    write(8'h07, 2, 1, 1'b0, 1'b1);
    wr_en = 1'b0;
    drain(200);

    // back-to-back frames
    baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0;
    lvl_max = 0; d0 = done_cnt;
    write(8'h11, 3, 0, 1'b0, 1'b1);
    write(8'h22, 3, 0, 1'b0, 1'b1);
    write(8'h33, 3, 0, 1'b0, 1'b1);
    wr_en = 1'b0;
    drain(300);
    n = done_cyc.size();
    check("b2b_count", done_cnt - d0, 3);
    check("b2b_level_peak", lvl_max, 2);
    check("b2b_gap1", done_cyc[n-2] - done_cyc[n-3], 30);
    check("b2b_gap2", done_cyc[n-1] - done_cyc[n-2], 30);

    // overflow: 10 writes, first popped, 8 buffered, 10th dropped
    baud_div = 16'd100; d0 = done_cnt;
    for (int i = 0; i < 10; i++) write(8'h40 + 8'(i * 7), 100, 0, 1'b0, i < 9);
    wr_en = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    clr_overflow = 1'b1;
    write(8'hEE, 100, 0, 1'b0, 1'b0);
    wr_en = 1'b0; clr_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    drain(12000);
    check("ovf_frames", done_cnt - d0, 9);

    // baud_div 0 behaves as 1
    baud_div = 16'd0;
    write(8'h3C, 1, 0, 1'b0, 1'b1);
    wr_en = 1'b0;
    drain(100);

    // reset in the middle of DATA with a second byte still queued
    d0 = done_cnt;
    write(8'h5A, 1, 0, 1'b0, 1'b1);
    write(8'hC3, 1, 0, 1'b0, 1'b1);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_level", level, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_empty", empty, 1);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle_tx", tx, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit half of the UART peripheral: accepts bytes written by the MIPS core through the UART CSR block, buffers them in a small synchronous FIFO, and serializes them onto the tx pin as 8N1 or 8E1/8O1 frames.
- Sits directly downstream of the CSR write decode (TXDATA register write -> wr_en/wr_data) and drives the top-level UART_tx pin.
- Status outputs feed back into the CSR STATUS register for read.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2.
- DATA_BITS, 8, payload bits per frame (fixed 8 in this release; parameterized for the package constant).
- BAUD_DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to enqueue (CSR TXDATA write data [7:0]).
- wr_en  in  1  enqueue strobe, one cycle per byte.
- baud_div  in  BAUD_DIV_W  clock cycles per bit, from CSR BAUD register.
- parity_en  in  1  1 = append parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity; ignored if parity_en = 0.
- clr_overflow  in  1  clears the overflow flag.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  FSM not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of every stop bit.
- tx  out  1  serial line, registered output.

Behaviour:
- Reset (clk edge with rst = 1): tx = 1, FSM = IDLE, FIFO emptied (level = 0, empty = 1, full = 0), overflow = 0, busy = 0, tx_done = 0. A reset mid-frame aborts the frame; tx returns to 1 on the same edge.
- FIFO push: a write is accepted iff wr_en && (!full || pop in the same cycle). Otherwise the byte is dropped and overflow is set.
- FIFO pointers wrap modulo FIFO_DEPTH. level = pushes - pops, and stays in the range 0..FIFO_DEPTH.
- clr_overflow clears overflow. If clr_overflow and a dropped write occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit-time counter: on entry to START, baud_div is latched into bit_len (a value of 0 is treated as 1), and parity_en/parity_odd are latched alongside it. Changing these inputs mid-frame has no effect on the current frame. Each bit holds tx for exactly bit_len cycles.
- IDLE: tx = 1. If !empty, pop the head byte into the shift register, drive tx = 0 and enter START. tx goes low on the edge after the one that wrote the byte, i.e. write at edge N -> tx = 0 after edge N+1.
- START -> DATA after bit_len cycles. DATA shifts 8 bits LSB first; bit index 0..7.
- After bit 7: go to PARITY if parity_en, else to STOP. The parity bit is the XOR of the data bits, XORed with parity_odd.
- STOP: tx = 1 for bit_len cycles. tx_done pulses high in the last cycle of STOP.
- At the end of STOP: if !empty, pop and go directly to START, with no idle cycle between frames. Otherwise go to IDLE.
- Frame length is (10 + parity_en) * bit_len cycles.
- busy = (state != IDLE).

Decomposition:
- UART_pkg gains:
  - UART_DATA_BITS = 8
  - UART_TX_FIFO_DEPTH = 8
  - UART_DEFAULT_BAUD_DIV = 434 (50 MHz / 115200)
  - typedef uart_tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - typedef uart_byte_t logic[7:0]
- Sub-module uart_sync_fifo (parameterized DEPTH/WIDTH, with push/pop/full/empty/level). It is reused later by the RX side.

Test Plan:
- Reset, then idle 20 cycles -> tx = 1, empty = 1, level = 0, busy = 0, overflow = 0.
- baud_div = 4, parity_en = 0, write 0xA5 -> tx goes low 1 cycle after the write edge. tx then shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles (40 cycles total). tx_done pulses in cycle 40; busy drops afterwards.
- baud_div = 2, parity_en = 1, parity_odd = 0, write 0x07 -> parity bit = 1, frame = 22 cycles. Repeat with parity_odd = 1 -> parity bit = 0.
- baud_div = 3, write 0x11, 0x22, 0x33 on consecutive cycles -> three back-to-back 30-cycle frames with no idle gap between them. level peaks at 2 (the first byte is popped immediately). Three tx_done pulses occur, 30 cycles apart.
- baud_div = 100, write 10 bytes on consecutive cycles with FIFO_DEPTH = 8 -> the first byte is popped into the shifter, 8 are buffered (full = 1), and the 10th is dropped with overflow = 1. After clr_overflow, overflow = 0. Exactly 9 frames are transmitted.
- baud_div = 0 -> each bit lasts 1 cycle (10-cycle frame). Assert rst in the middle of the DATA state -> tx = 1, FIFO empty, and no tx_done pulse.
